// File: rtl/pc_sequencer.sv
// Program-counter sequencer: RUN/HALTED FSM selecting JR, J/JAL, branch or sequential next PC.
// Optional misaligned-target trap enabled by defining PC_TRAP_EN (adds trap and epc ports).
module pc_sequencer #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_W-1:0] TRAP_VECTOR  = 'h80
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              pc_en,
  input  logic              halt,
  input  logic [1:0]        pc_src,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] rdat1,
  input  logic [15:0]       imm16,
  input  logic [25:0]       imm26,
  output logic [ADDR_W-1:0] imemaddr,
  output logic [ADDR_W-1:0] pc_plus_4,
  output logic              redirect,
  output logic              halted,
  output logic [31:0]       instr_count
`ifdef PC_TRAP_EN
  ,
  output logic              trap,
  output logic [ADDR_W-1:0] epc
`endif
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

  // Elaboration-time parameter sanity: jump splicing needs at least 28 PC bits,
  // and a misaligned trap vector would make every trap re-trap.
  if (ADDR_W < 28) begin : g_bad_addr_w
    $error("pc_sequencer: ADDR_W must be 28 or more");
  end
  if (TRAP_VECTOR[1:0] != 2'b00) begin : g_bad_trap_vector
    $error("pc_sequencer: TRAP_VECTOR must be word aligned");
  end

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [31:0]       count_reg, count_next;
  logic              redirect_reg, redirect_next;
  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] br_offset;
  logic [ADDR_W-1:0] pc_target;
  logic              target_nonseq;

`ifdef PC_TRAP_EN
  logic              trap_reg, trap_next;
  logic [ADDR_W-1:0] epc_reg, epc_next;
`endif

  assign pc_seq    = pc_reg + ADDR_W'(4);
  assign br_offset = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};

  always_comb begin
    pc_target     = pc_seq;
    target_nonseq = 1'b0;
    case (pc_src)
      2'd0: begin
        pc_target     = rdat1;
        target_nonseq = 1'b1;
      end
      2'd1: begin
        pc_target     = {pc_seq[ADDR_W-1:28], imm26, 2'b00};
        target_nonseq = 1'b1;
      end
      2'd2: begin
        if (br_taken) begin
          pc_target     = pc_seq + br_offset;
          target_nonseq = 1'b1;
        end
      end
      default: begin
        pc_target     = pc_seq;
        target_nonseq = 1'b0;
      end
    endcase
  end

  // Halt beats any update in the same cycle; HALTED is only left through reset.
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    count_next    = count_reg;
    redirect_next = 1'b0;
`ifdef PC_TRAP_EN
    trap_next     = 1'b0;
    epc_next      = epc_reg;
`endif
    case (state_reg)
      RUN: begin
        if (halt) begin
          state_next = HALTED;
        end else if (pc_en) begin
          pc_next       = pc_target;
          redirect_next = target_nonseq;
          count_next    = (count_reg == COUNT_MAX) ? count_reg : count_reg + 32'd1;
`ifdef PC_TRAP_EN
          if (pc_target[1:0] != 2'b00) begin
            pc_next       = TRAP_VECTOR;
            epc_next      = pc_reg;
            trap_next     = 1'b1;
            redirect_next = 1'b1;
          end
`endif
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= RUN;
      pc_reg       <= RESET_VECTOR;
      count_reg    <= '0;
      redirect_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      count_reg    <= count_next;
      redirect_reg <= redirect_next;
    end
  end

`ifdef PC_TRAP_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      trap_reg <= 1'b0;
      epc_reg  <= '0;
    end else begin
      trap_reg <= trap_next;
      epc_reg  <= epc_next;
    end
  end

  assign trap = trap_reg;
  assign epc  = epc_reg;
`endif

  assign imemaddr    = pc_reg;
  assign pc_plus_4   = pc_seq;
  assign redirect    = redirect_reg;
  assign halted      = (state_reg == HALTED);
  assign instr_count = count_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table plus hand-written halt/reset/saturation sequences.
// Trap checks are compiled in when PC_TRAP_EN is defined.
module tb_pc_sequencer;

  localparam int ADDR_W = 32;

  logic              CLK;
  logic              RST;
  logic              pc_en;
  logic              halt;
  logic [1:0]        pc_src;
  logic              br_taken;
  logic [ADDR_W-1:0] rdat1;
  logic [15:0]       imm16;
  logic [25:0]       imm26;
  logic [ADDR_W-1:0] imemaddr;
  logic [ADDR_W-1:0] pc_plus_4;
  logic              redirect;
  logic              halted;
  logic [31:0]       instr_count;
`ifdef PC_TRAP_EN
  logic              trap;
  logic [ADDR_W-1:0] epc;
`endif

  pc_sequencer #(
    .ADDR_W      (ADDR_W),
    .RESET_VECTOR(32'h0),
    .TRAP_VECTOR (32'h80)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .pc_en      (pc_en),
    .halt       (halt),
    .pc_src     (pc_src),
    .br_taken   (br_taken),
    .rdat1      (rdat1),
    .imm16      (imm16),
    .imm26      (imm26),
    .imemaddr   (imemaddr),
    .pc_plus_4  (pc_plus_4),
    .redirect   (redirect),
    .halted     (halted),
    .instr_count(instr_count)
`ifdef PC_TRAP_EN
    ,
    .trap       (trap),
    .epc        (epc)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        en;
    logic        hlt;
    logic [1:0]  src;
    logic        br;
    logic [31:0] rd;
    logic [15:0] i16;
    logic [25:0] i26;
    logic [31:0] e_pc;
    logic        e_red;
    logic [31:0] e_cnt;
    logic        e_hlt;
    logic        e_trap;
    logic [31:0] e_epc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        red;
    logic [31:0] cnt;
    logic        hlt;
    logic        trp;
    logic [31:0] epc;
    string       tag;
  } exp_t;

`ifdef PC_TRAP_EN
  localparam logic [31:0] MIS_PC   = 32'h80;
  localparam logic [31:0] AFTER_PC = 32'h84;
  localparam logic        MIS_TRAP = 1'b1;
  localparam logic [31:0] MIS_EPC  = 32'h40;
`else
  localparam logic [31:0] MIS_PC   = 32'h102;
  localparam logic [31:0] AFTER_PC = 32'h106;
  localparam logic        MIS_TRAP = 1'b0;
  localparam logic [31:0] MIS_EPC  = 32'h0;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  vec_t tbl[19];

  function automatic vec_t mk(input logic en, input logic hlt, input logic [1:0] src,
                              input logic br, input logic [31:0] rd, input logic [15:0] i16,
                              input logic [25:0] i26, input logic [31:0] e_pc, input logic e_red,
                              input logic [31:0] e_cnt, input logic e_hlt, input logic e_trap,
                              input logic [31:0] e_epc);
    vec_t v;
    v.en = en; v.hlt = hlt; v.src = src; v.br = br; v.rd = rd; v.i16 = i16; v.i26 = i26;
    v.e_pc = e_pc; v.e_red = e_red; v.e_cnt = e_cnt; v.e_hlt = e_hlt;
    v.e_trap = e_trap; v.e_epc = e_epc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    chk({e.tag, " imemaddr"}, imemaddr, e.pc);
    chk({e.tag, " pc_plus_4"}, pc_plus_4, e.pc + 32'd4);
    chk({e.tag, " redirect"}, {31'b0, redirect}, {31'b0, e.red});
    chk({e.tag, " instr_count"}, instr_count, e.cnt);
    chk({e.tag, " halted"}, {31'b0, halted}, {31'b0, e.hlt});
`ifdef PC_TRAP_EN
    chk({e.tag, " trap"}, {31'b0, trap}, {31'b0, e.trp});
    chk({e.tag, " epc"}, epc, e.epc);
`endif
  endtask

  task automatic step(input string tag, input vec_t v);
    exp_t e;
    @(negedge CLK);
    pc_en = v.en; halt = v.hlt; pc_src = v.src; br_taken = v.br;
    rdat1 = v.rd; imm16 = v.i16; imm26 = v.i26;
    e.pc = v.e_pc; e.red = v.e_red; e.cnt = v.e_cnt; e.hlt = v.e_hlt;
    e.trp = v.e_trap; e.epc = v.e_epc; e.tag = tag;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    check_outputs(e);
    $display("step %s: pc=%h redirect=%0b count=%0d halted=%0b", tag, imemaddr, redirect,
             instr_count, halted);
  endtask

  // Reset pulse that rises and falls strictly between two rising edges.
  task automatic mid_reset(input string tag);
    @(negedge CLK);
    pc_en = 1'b0;
    halt  = 1'b0;
    #2 RST = 1'b1;
    #1;
    chk({tag, " imemaddr"}, imemaddr, 32'h0);
    chk({tag, " redirect"}, {31'b0, redirect}, 32'h0);
    chk({tag, " halted"}, {31'b0, halted}, 32'h0);
    chk({tag, " instr_count"}, instr_count, 32'h0);
`ifdef PC_TRAP_EN
    chk({tag, " trap"}, {31'b0, trap}, 32'h0);
    chk({tag, " epc"}, epc, 32'h0);
`endif
    $display("reset %s: pc=%h count=%0d halted=%0b", tag, imemaddr, instr_count, halted);
    #1 RST = 1'b0;
  endtask

  initial begin
    //              en hl src br rdat1          imm16     imm26          exp_pc         red cnt     hlt trap      epc
    tbl[0]  = mk(1, 0, 3, 0, 32'h0,         16'h0,    26'h0,       32'h4,         0, 32'd1,  0, 0,        32'h0);
    tbl[1]  = mk(1, 0, 3, 0, 32'h0,         16'h0,    26'h0,       32'h8,         0, 32'd2,  0, 0,        32'h0);
    tbl[2]  = mk(1, 0, 3, 0, 32'h0,         16'h0,    26'h0,       32'hC,         0, 32'd3,  0, 0,        32'h0);
    tbl[3]  = mk(0, 0, 0, 1, 32'h999,       16'h0,    26'h0,       32'hC,         0, 32'd3,  0, 0,        32'h0);
    tbl[4]  = mk(1, 0, 0, 0, 32'h100,       16'h0,    26'h0,       32'h100,       1, 32'd4,  0, 0,        32'h0);
    tbl[5]  = mk(1, 0, 2, 1, 32'h0,         16'hFFFF, 26'h0,       32'h100,       1, 32'd5,  0, 0,        32'h0);
    tbl[6]  = mk(1, 0, 2, 0, 32'h0,         16'hFFFF, 26'h0,       32'h104,       0, 32'd6,  0, 0,        32'h0);
    tbl[7]  = mk(1, 0, 2, 1, 32'h0,         16'h0010, 26'h0,       32'h148,       1, 32'd7,  0, 0,        32'h0);
    tbl[8]  = mk(1, 0, 0, 0, 32'h4000_0010, 16'h0,    26'h0,       32'h4000_0010, 1, 32'd8,  0, 0,        32'h0);
    tbl[9]  = mk(1, 0, 1, 0, 32'h0,         16'h0,    26'h3,       32'h4000_000C, 1, 32'd9,  0, 0,        32'h0);
    tbl[10] = mk(1, 0, 0, 0, 32'h200,       16'h0,    26'h0,       32'h200,       1, 32'd10, 0, 0,        32'h0);
    tbl[11] = mk(1, 0, 3, 1, 32'h0,         16'h0,    26'h0,       32'h204,       0, 32'd11, 0, 0,        32'h0);
    tbl[12] = mk(1, 0, 1, 0, 32'h0,         16'h0,    26'h3FF_FFFF, 32'h0FFF_FFFC, 1, 32'd12, 0, 0,       32'h0);
    tbl[13] = mk(1, 0, 0, 0, 32'hFFFF_FFFC, 16'h0,    26'h0,       32'hFFFF_FFFC, 1, 32'd13, 0, 0,        32'h0);
    tbl[14] = mk(1, 0, 3, 0, 32'h0,         16'h0,    26'h0,       32'h0,         0, 32'd14, 0, 0,        32'h0);
    tbl[15] = mk(1, 0, 2, 1, 32'h0,         16'hFFFF, 26'h0,       32'h0,         1, 32'd15, 0, 0,        32'h0);
    tbl[16] = mk(1, 0, 0, 0, 32'h40,        16'h0,    26'h0,       32'h40,        1, 32'd16, 0, 0,        32'h0);
    tbl[17] = mk(1, 0, 0, 0, 32'h102,       16'h0,    26'h0,       MIS_PC,        1, 32'd17, 0, MIS_TRAP, MIS_EPC);
    tbl[18] = mk(1, 0, 3, 0, 32'h0,         16'h0,    26'h0,       AFTER_PC,      0, 32'd18, 0, 0,        MIS_EPC);

    RST = 1'b1; pc_en = 1'b0; halt = 1'b0; pc_src = 2'd3; br_taken = 1'b0;
    rdat1 = '0; imm16 = '0; imm26 = '0;
    #1;
    chk("reset imemaddr", imemaddr, 32'h0);
    chk("reset redirect", {31'b0, redirect}, 32'h0);
    chk("reset halted", {31'b0, halted}, 32'h0);
    chk("reset instr_count", instr_count, 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 19; i++) begin
      step($sformatf("vec%0d", i), tbl[i]);
    end

    // Halt together with pc_en (and a misaligned target) must freeze everything.
    step("jr_0x20", mk(1, 0, 0, 0, 32'h20, 16'h0, 26'h0, 32'h20, 1, 32'd19, 0, 0, MIS_EPC));
    step("halt", mk(1, 1, 0, 0, 32'h501, 16'h0, 26'h0, 32'h20, 0, 32'd19, 1, 0, MIS_EPC));
    for (int i = 0; i < 10; i++) begin
      step($sformatf("halted%0d", i),
           mk(1, 0, 0, 1, 32'h501, 16'h0, 26'h3, 32'h20, 0, 32'd19, 1, 0, MIS_EPC));
    end
    mid_reset("rst_halted");

    step("first_after_rst", mk(1, 0, 3, 0, 32'h0, 16'h0, 26'h0, 32'h4, 0, 32'd1, 0, 0, 32'h0));
    step("jr_0x300", mk(1, 0, 0, 0, 32'h300, 16'h0, 26'h0, 32'h300, 1, 32'd2, 0, 0, 32'h0));
    mid_reset("rst_redirect");

    step("jr_top", mk(1, 0, 0, 0, 32'hFFFF_FFFC, 16'h0, 26'h0, 32'hFFFF_FFFC, 1, 32'd1, 0, 0, 32'h0));
    step("wrap", mk(1, 0, 3, 0, 32'h0, 16'h0, 26'h0, 32'h0, 0, 32'd2, 0, 0, 32'h0));

    force dut.count_reg = 32'hFFFF_FFFF;
    #1;
    release dut.count_reg;
    step("sat_seq", mk(1, 0, 3, 0, 32'h0, 16'h0, 26'h0, 32'h4, 0, 32'hFFFF_FFFF, 0, 0, 32'h0));
    step("sat_br", mk(1, 0, 2, 1, 32'h0, 16'h0003, 26'h0, 32'h14, 1, 32'hFFFF_FFFF, 0, 0, 32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, giving the PC width in bits; legal values are 28 and above.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 0, giving the PC value loaded on reset.
REQ-003 The block SHALL have parameter TRAP_VECTOR, default 'h80, giving the trap target (used only when PC_TRAP_EN is defined).
REQ-004 The block SHALL have the following ports, clock and reset first:
  CLK  in  1  sole clock; all state changes on the rising edge.
  RST  in  1  asynchronous, active-high reset.
  pc_en  in  1  advance request for this cycle.
  halt  in  1  stop request.
  pc_src  in  2  next-PC source: 0=JR, 1=J/JAL, 2=branch, 3=sequential.
  br_taken  in  1  branch condition; used only when pc_src=2.
  rdat1  in  ADDR_W  JR target.
  imm16  in  16  branch offset, in words, signed.
  imm26  in  26  jump index.
  imemaddr  out  ADDR_W  current PC.
  pc_plus_4  out  ADDR_W  PC+4.
  redirect  out  1  one-cycle pulse: the last update was non-sequential.
  halted  out  1  high while in HALTED.
  instr_count  out  32  number of PC updates performed.
  trap  out  1  one-cycle trap pulse (PC_TRAP_EN only).
  epc  out  ADDR_W  faulting PC (PC_TRAP_EN only).

Function
REQ-005 The state machine SHALL have states RUN and HALTED; it SHALL reset to RUN.
REQ-006 In RUN with halt=1, the block SHALL go to HALTED on the next edge and SHALL NOT update PC that cycle, regardless of pc_en.
REQ-007 HALTED SHALL be left only by reset; PC, instr_count and epc SHALL hold, and redirect and trap SHALL be 0.
REQ-008 In RUN with halt=0 and pc_en=1, the block SHALL load PC_next; with pc_en=0, PC SHALL hold.
REQ-009 PC_next SHALL be selected by pc_src as follows:
  - 0: rdat1.
  - 1: {pc_plus_4[ADDR_W-1:28], imm26, 2'b00}.
  - 2 with br_taken=1: pc_plus_4 + (sign-extended imm16 << 2).
  - 2 with br_taken=0, and 3: pc_plus_4.
REQ-010 All PC arithmetic SHALL be modulo 2^ADDR_W; wrap-around SHALL be silent (all-ones-minus-3 + 4 = 0).
REQ-011 imemaddr SHALL equal the PC register with zero combinational dependence on inputs; pc_plus_4 SHALL equal PC+4.
REQ-012 redirect SHALL be registered and asserted for exactly the cycle after an update whose source was 0, 1, or 2 with br_taken=1.
REQ-013 instr_count SHALL increment by 1 per PC update and SHALL saturate at 32'hFFFF_FFFF.
REQ-014 pc_src and br_taken SHALL be ignored on cycles with no update.

Reset
REQ-015 RST=1 SHALL immediately and asynchronously set PC=RESET_VECTOR, state=RUN, redirect=0, halted=0, instr_count=0, trap=0, epc=0.
REQ-016 Reset asserted mid-operation, including in HALTED or during a redirect, SHALL override all inputs.
REQ-017 The first update after reset release SHALL occur on the first edge with RST=0, pc_en=1 and halt=0.

Configuration
REQ-018 Macro PC_TRAP_EN SHALL, when defined, check every PC update: if PC_next[1:0]!=0, PC SHALL load TRAP_VECTOR, epc SHALL capture the current PC, trap SHALL pulse for one cycle, and redirect SHALL pulse.
REQ-019 A trap update SHALL increment instr_count; a halt in the same cycle SHALL win, so no trap occurs and PC holds.
REQ-020 When PC_TRAP_EN is undefined, the trap and epc ports SHALL be absent, and misaligned targets SHALL be loaded unchanged.

Verification
REQ-021 Bench SHALL cover: reset, RESET_VECTOR=0, pc_en=1, pc_src=3 for 3 cycles -> imemaddr 4, 8, 12; instr_count=3; redirect=0.
REQ-022 Bench SHALL cover: PC=0x100, pc_src=2, br_taken=1, imm16=16'hFFFF -> PC=0x100; redirect=1 next cycle; br_taken=0 -> PC=0x104.
REQ-023 Bench SHALL cover: PC=0x4000_0010, pc_src=1, imm26=26'h3 -> PC=0x4000_000C; pc_src=0, rdat1=0x200 -> PC=0x200.
REQ-024 Bench SHALL cover: halt=1 and pc_en=1 together at PC=0x20 -> halted=1, PC stays 0x20 for 10 cycles; RST pulse mid-cycle -> PC=0 immediately.
REQ-025 Bench SHALL cover: ADDR_W=32, PC=0xFFFF_FFFC, sequential update -> PC=0; instr_count forced to all-ones -> stays saturated.
REQ-026 Bench SHALL cover, with PC_TRAP_EN: PC=0x40, pc_src=0, rdat1=0x102 -> PC=0x80, epc=0x40, trap=1 for one cycle.
